// File: rtl/mul_ctrl.sv
// mul_ctrl: execute-stage sequencer around the 1-cycle 32x32 multiplier.
// Latches the EX operands, issues a single start pulse, and captures the
// 64-bit product. It then applies MUL/MULT[U]/MADD[U]/MSUB[U] to HI/LO or to
// the GPR result. It owns HI/LO (including MTHI/MTLO) and stalls EX while busy.
//
// Ports:
//   clk, rst (async active-low), flush (sync, active-high)
//   ex_valid_i, ex_op_i[2:0], opdata1_i, opdata2_i   : request from EX
//   mthi_i, mtlo_i, wdata_i                          : direct HI/LO writes
//   mul_op1_o, mul_op2_o, mul_signed_o, mul_start_o  : to multiplier
//   mul_result_i[63:0], mul_ready_i                  : from multiplier
//   stall_o, done_o, gpr_result_o, gpr_valid_o       : to pipeline
//   hi_o, lo_o                                       : architectural HI/LO
module mul_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        ex_valid_i,
    input  logic [2:0]  ex_op_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic        mthi_i,
    input  logic        mtlo_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] mul_op1_o,
    output logic [31:0] mul_op2_o,
    output logic        mul_signed_o,
    output logic        mul_start_o,
    input  logic [63:0] mul_result_i,
    input  logic        mul_ready_i,
    output logic        stall_o,
    output logic        done_o,
    output logic [31:0] gpr_result_o,
    output logic        gpr_valid_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        ACC,
        DONE
    } state_t;

    typedef enum logic [2:0] {
        OP_NONE  = 3'd0,
        OP_MUL   = 3'd1,
        OP_MULT  = 3'd2,
        OP_MULTU = 3'd3,
        OP_MADD  = 3'd4,
        OP_MADDU = 3'd5,
        OP_MSUB  = 3'd6,
        OP_MSUBU = 3'd7
    } op_t;

    state_t      state_q, state_d;
    op_t         op_q, op_d;
    logic [31:0] op1_q, op1_d;
    logic [31:0] op2_q, op2_d;
    logic        signed_q, signed_d;
    logic [63:0] prod_q, prod_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] gpr_q, gpr_d;

    logic        req;
    logic        stall;
    logic        start;
    logic        done;
    logic        gpr_valid;

    assign req = ex_valid_i && (ex_op_i != 3'd0);

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        op1_d     = op1_q;
        op2_d     = op2_q;
        signed_d  = signed_q;
        prod_d    = prod_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        gpr_d     = gpr_q;
        stall     = 1'b0;
        start     = 1'b0;
        done      = 1'b0;
        gpr_valid = 1'b0;

        case (state_q)
            IDLE: begin
                if (!flush) begin
                    if (req) begin
                        stall    = 1'b1;
                        op_d     = op_t'(ex_op_i);
                        op1_d    = opdata1_i;
                        op2_d    = opdata2_i;
                        signed_d = (ex_op_i == OP_MUL)  || (ex_op_i == OP_MULT) ||
                                   (ex_op_i == OP_MADD) || (ex_op_i == OP_MSUB);
                        state_d  = ISSUE;
                    end
                    if (mthi_i) hi_d = wdata_i;
                    if (mtlo_i) lo_d = wdata_i;
                end
            end
            ISSUE: begin
                stall   = 1'b1;
                start   = !flush;
                state_d = WAIT;
            end
            WAIT: begin
                stall = 1'b1;
                if (mul_ready_i) begin
                    prod_d  = mul_result_i;
                    state_d = ACC;
                end
            end
            ACC: begin
                stall = 1'b1;
                case (op_q)
                    OP_MUL:            gpr_d        = prod_q[31:0];
                    OP_MULT, OP_MULTU: {hi_d, lo_d} = prod_q;
                    OP_MADD, OP_MADDU: {hi_d, lo_d} = {hi_q, lo_q} + prod_q;
                    OP_MSUB, OP_MSUBU: {hi_d, lo_d} = {hi_q, lo_q} - prod_q;
                    default: ;
                endcase
                state_d = DONE;
            end
            DONE: begin
                done      = 1'b1;
                gpr_valid = (op_q == OP_MUL);
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Flush abandons the operation: any architectural write on this edge is dropped.
        if (flush) begin
            state_d = IDLE;
            hi_d    = hi_q;
            lo_d    = lo_q;
            gpr_d   = gpr_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            op_q     <= OP_NONE;
            op1_q    <= '0;
            op2_q    <= '0;
            signed_q <= 1'b0;
            prod_q   <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            gpr_q    <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            op1_q    <= op1_d;
            op2_q    <= op2_d;
            signed_q <= signed_d;
            prod_q   <= prod_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            gpr_q    <= gpr_d;
        end
    end

    assign mul_op1_o    = op1_q;
    assign mul_op2_o    = op2_q;
    assign mul_signed_o = signed_q;
    assign mul_start_o  = start;
    // The IDLE request path is combinational from EX, so hold it low while in reset.
    assign stall_o      = stall && rst;
    assign done_o       = done;
    assign gpr_result_o = gpr_q;
    assign gpr_valid_o  = gpr_valid;
    assign hi_o         = hi_q;
    assign lo_o         = lo_q;

endmodule

// File: tb/tb_mul_ctrl.sv
module tb_mul_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        ex_valid = 1'b0;
    logic [2:0]  ex_op = 3'd0;
    logic [31:0] opdata1 = '0;
    logic [31:0] opdata2 = '0;
    logic        mthi = 1'b0;
    logic        mtlo = 1'b0;
    logic [31:0] wdata = '0;
    logic [31:0] mul_op1, mul_op2;
    logic        mul_signed, mul_start;
    logic [63:0] mul_result;
    logic        mul_ready;
    logic        stall, done, gpr_valid;
    logic [31:0] gpr_result, hi, lo;

    logic        mul_rdy_q;
    logic        extra_ready = 1'b0;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    logic [31:0] ref_hi = '0;
    logic [31:0] ref_lo = '0;
    logic [31:0] ref_gpr = '0;

    always #5 clk = ~clk;

    mul_ctrl dut (
        .clk          (clk),
        .rst          (rst_n),
        .flush        (flush),
        .ex_valid_i   (ex_valid),
        .ex_op_i      (ex_op),
        .opdata1_i    (opdata1),
        .opdata2_i    (opdata2),
        .mthi_i       (mthi),
        .mtlo_i       (mtlo),
        .wdata_i      (wdata),
        .mul_op1_o    (mul_op1),
        .mul_op2_o    (mul_op2),
        .mul_signed_o (mul_signed),
        .mul_start_o  (mul_start),
        .mul_result_i (mul_result),
        .mul_ready_i  (mul_ready),
        .stall_o      (stall),
        .done_o       (done),
        .gpr_result_o (gpr_result),
        .gpr_valid_o  (gpr_valid),
        .hi_o         (hi),
        .lo_o         (lo)
    );

    // 1-cycle multiplier: ready the cycle after start, product from the held operands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) mul_rdy_q <= 1'b0;
        else        mul_rdy_q <= mul_start;
    end
    assign mul_ready = mul_rdy_q | extra_ready;

    always_comb begin
        logic signed [63:0] sa, sb;
        sa = $signed(mul_op1);
        sb = $signed(mul_op2);
        if (mul_signed) mul_result = sa * sb;
        else            mul_result = {32'd0, mul_op1} * {32'd0, mul_op2};
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic is_signed_op(input logic [2:0] op);
        return op inside {3'd1, 3'd2, 3'd4, 3'd6};
    endfunction

    // Reference: architectural effect of one operation on HI/LO/GPR.
    function automatic void ref_exec(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                     input logic [31:0] h, input logic [31:0] l, input logic [31:0] g,
                                     output logic [31:0] nh, output logic [31:0] nl, output logic [31:0] ng);
        logic [63:0] p, acc;
        if (is_signed_op(op)) p = {{32{a[31]}}, a} * {{32{b[31]}}, b};
        else                  p = {32'd0, a} * {32'd0, b};
        acc = {h, l};
        ng  = g;
        case (op)
            3'd1:       ng  = p[31:0];
            3'd2, 3'd3: acc = p;
            3'd4, 3'd5: acc = acc + p;
            3'd6, 3'd7: acc = acc - p;
            default: ;
        endcase
        nh = acc[63:32];
        nl = acc[31:0];
    endfunction

    task automatic mt_write(input logic h, input logic l, input logic [31:0] d, input logic fl);
        @(negedge clk);
        mthi = h; mtlo = l; wdata = d; flush = fl;
        @(negedge clk);
        mthi = 1'b0; mtlo = 1'b0; flush = 1'b0;
    endtask

    task automatic preset(input logic [31:0] h, input logic [31:0] l);
        if (h == l) mt_write(1'b1, 1'b1, h, 1'b0);
        else begin
            mt_write(1'b1, 1'b0, h, 1'b0);
            mt_write(1'b0, 1'b1, l, 1'b0);
        end
        #1;
        chk("mt_hi", hi, h);
        chk("mt_lo", lo, l);
        ref_hi = h;
        ref_lo = l;
    endtask

    // Full operation with per-cycle timing checks, T = request cycle (k=0).
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eh, input logic [31:0] el, input logic [31:0] eg);
        @(negedge clk);
        ex_valid = 1'b1; ex_op = op; opdata1 = a; opdata2 = b;
        #1;
        for (int k = 0; k <= 4; k++) begin
            if (k > 0) begin
                @(negedge clk);
                #1;
            end
            chk("stall", stall, 64'(k <= 3));
            chk("start", mul_start, 64'(k == 1));
            chk("done", done, 64'(k == 4));
            chk("gpr_valid", gpr_valid, 64'((k == 4) && (op == 3'd1)));
            if (k >= 1) begin
                chk("op1", mul_op1, a);
                chk("op2", mul_op2, b);
                chk("signed", mul_signed, is_signed_op(op));
            end
        end
        chk("hi", hi, eh);
        chk("lo", lo, el);
        chk("gpr", gpr_result, eg);
        @(negedge clk);
        ex_valid = 1'b0; ex_op = 3'd0;
        #1;
        chk("stall_after", stall, 0);
        chk("start_after", mul_start, 0);
    endtask

    // Request an op, flush it in cycle k_fl, and confirm nothing architectural changed.
    task automatic flush_at(input logic [2:0] op, input int k_fl);
        @(negedge clk);
        ex_valid = 1'b1; ex_op = op; opdata1 = 32'd3; opdata2 = 32'd4;
        for (int k = 1; k <= k_fl; k++) @(negedge clk);
        flush = 1'b1; ex_valid = 1'b0; ex_op = 3'd0;
        #1;
        chk("flush_start", mul_start, 0);
        @(negedge clk);
        flush = 1'b0;
        #1;
        chk("flush_stall", stall, 0);
        for (int k = 0; k < 4; k++) begin
            chk("flush_done", done, 0);
            chk("flush_gv", gpr_valid, 0);
            chk("flush_hi", hi, ref_hi);
            chk("flush_lo", lo, ref_lo);
            chk("flush_gpr", gpr_result, ref_gpr);
            @(negedge clk);
            #1;
        end
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a, b, pre_hi, pre_lo, exp_hi, exp_lo, exp_gpr;
    } vec_t;

    vec_t vecs[9];

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 3))
            0:       return 32'hFFFF_FFFF;
            1:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] nh, nl, ng, a, b, h, l;
        logic [2:0]  op;

        vecs[0] = '{3'd2, 32'hFFFF_FFFF, 32'h2, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0};
        vecs[1] = '{3'd3, 32'hFFFF_FFFF, 32'h2, 32'h0, 32'h0, 32'h0000_0001, 32'hFFFF_FFFE, 32'h0};
        vecs[2] = '{3'd4, 32'h3, 32'h4, 32'h0, 32'h5, 32'h0, 32'd17, 32'h0};
        vecs[3] = '{3'd6, 32'h10, 32'h2, 32'h0, 32'd17, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 32'h0};
        vecs[4] = '{3'd5, 32'h1, 32'h1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0};
        vecs[5] = '{3'd1, 32'hFFFF_FFF9, 32'h6, 32'h1234_5678, 32'h9ABC_DEF0, 32'h1234_5678, 32'h9ABC_DEF0, 32'hFFFF_FFD6};
        vecs[6] = '{3'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0000_0001, 32'hFFFF_FFFF, 32'hFFFF_FFD6};
        vecs[7] = '{3'd4, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'hFFFF_FFFF, 32'h1, 32'h0, 32'hFFFF_FFD6};
        vecs[8] = '{3'd2, 32'h8000_0000, 32'h8000_0000, 32'h7, 32'h9, 32'h4000_0000, 32'h0, 32'hFFFF_FFD6};

        // Reset state
        #12;
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);
        chk("rst_op1", mul_op1, 0);
        chk("rst_signed", mul_signed, 0);
        chk("rst_stall", stall, 0);
        chk("rst_done", done, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed table
        foreach (vecs[i]) begin
            preset(vecs[i].pre_hi, vecs[i].pre_lo);
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp_hi, vecs[i].exp_lo, vecs[i].exp_gpr);
            ref_hi  = vecs[i].exp_hi;
            ref_lo  = vecs[i].exp_lo;
            ref_gpr = vecs[i].exp_gpr;
        end

        // Flush in IDLE blocks MT writes
        mt_write(1'b1, 1'b1, 32'hDEAD_BEEF, 1'b1);
        #1;
        chk("flush_mt_hi", hi, ref_hi);
        chk("flush_mt_lo", lo, ref_lo);

        // Stray ready in IDLE is ignored
        @(negedge clk);
        extra_ready = 1'b1;
        @(negedge clk);
        extra_ready = 1'b0;
        #1;
        chk("stray_rdy_stall", stall, 0);
        chk("stray_rdy_done", done, 0);
        chk("stray_rdy_hi", hi, ref_hi);

        // Flushes in ISSUE, WAIT and ACC
        preset(32'h1111_1111, 32'h2222_2222);
        flush_at(3'd4, 1);
        flush_at(3'd4, 2);
        flush_at(3'd6, 3);
        flush_at(3'd1, 3);

        // Reset asserted in ACC
        @(negedge clk);
        ex_valid = 1'b1; ex_op = 3'd6; opdata1 = 32'h5; opdata2 = 32'h7;
        repeat (3) @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("racc_hi", hi, 0);
        chk("racc_lo", lo, 0);
        chk("racc_op1", mul_op1, 0);
        chk("racc_op2", mul_op2, 0);
        chk("racc_signed", mul_signed, 0);
        chk("racc_start", mul_start, 0);
        chk("racc_stall", stall, 0);
        chk("racc_done", done, 0);
        chk("racc_gpr", gpr_result, 0);
        chk("racc_gv", gpr_valid, 0);
        ex_valid = 1'b0; ex_op = 3'd0;
        @(negedge clk);
        rst_n = 1'b1;
        ref_hi = '0; ref_lo = '0; ref_gpr = '0;

        // Randomized operations against the reference model
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                h = $urandom;
                l = $urandom;
                preset(h, l);
            end
            op = 3'($urandom_range(1, 7));
            a  = pick();
            b  = pick();
            ref_exec(op, a, b, ref_hi, ref_lo, ref_gpr, nh, nl, ng);
            run_op(op, a, b, nh, nl, ng);
            ref_hi = nh; ref_lo = nl; ref_gpr = ng;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
